led7_scroll_mux: RTL and testbench

//  - Parametrised N-channel character mux driving NDIG active-low 7-seg digits, HEX[7:0] per digit, bit7 = DP.
//  - Manual mode: SEL picks one channel; its character appears on digit 0.
//  - Auto mode: channels 0..NCH-1 are stepped on a prescaled tick and scrolled right-to-left across all digits.
//  - Sits between board switches and the HEX displays; replaces the fixed 5:1 mux and its decoder.

---
 rtl/led7_pkg.sv | 24 ++
 rtl/led7_prescaler.sv | 41 ++++
 rtl/led7_scroll_mux.sv | 102 ++++++++++
 tb/tb_led7_scroll_mux.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led7_pkg.sv
// Shared segment codes and character decoder for the scrolling 7-seg mux.
// Segment patterns are active-low; bit 7 is the decimal point.
package led7_pkg;

  localparam int unsigned CHR_W = 3;

  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_dec(input logic [CHR_W-1:0] code);
    case (code)
      3'd0:    return SEG_H;
      3'd1:    return SEG_E;
      3'd2:    return SEG_L;
      3'd3:    return SEG_L;
      3'd4:    return SEG_O;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/led7_prescaler.sv
// Scroll-step prescaler: counts 0..DIV-1 and wraps, with clear and hold.
// Clear wins over hold; tick is asserted only in the cycle the count wraps.
module led7_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned   CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led7_scroll_mux.sv
// N-channel character mux for NDIG active-low 7-seg digits: manual select
// on digit 0, or auto-scroll of all channels right-to-left on a prescaled tick.
module led7_scroll_mux
  import led7_pkg::*;
#(
  parameter int unsigned NCH  = 8,
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 50_000_000,
  localparam int unsigned SW_W = $clog2(NCH)
) (
  input  logic                   CLOCK_50,
  input  logic                   RST_N,
  input  logic                   MODE,
  input  logic                   PAUSE,
  input  logic [SW_W-1:0]        SEL,
  input  logic [NCH*CHR_W-1:0]   DATA,
  output logic [NDIG*8-1:0]      HEX,
  output logic [SW_W-1:0]        CUR_IDX,
  output logic                   TICK
);

  logic                mode_q, mode_d;
  logic [SW_W-1:0]     idx_q, idx_d;
  logic [NDIG*8-1:0]   hex_q, hex_d;
  logic                tick_q, tick_d;
  logic                mode_chg;
  logic                presc_tick;
  logic [SW_W-1:0]     idx_nxt;
  logic [7:0]          sel_seg;
  logic [7:0]          nxt_seg;

  assign mode_chg = (MODE != mode_q);

  // Prescaler only runs in a settled auto mode.
  led7_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk_i  (CLOCK_50),
    .rst_ni (RST_N),
    .clr_i  (mode_chg | ~mode_q),
    .hold_i (PAUSE),
    .tick_o (presc_tick)
  );

  assign idx_nxt = (idx_q == SW_W'(NCH - 1)) ? '0 : idx_q + 1'b1;

  // Out-of-range selects fall through to blank.
  always_comb begin
    sel_seg = SEG_BLANK;
    nxt_seg = SEG_BLANK;
    for (int k = 0; k < int'(NCH); k++) begin
      if (SEL == SW_W'(k)) begin
        sel_seg = seg_dec(DATA[k*CHR_W +: CHR_W]);
      end
      if (idx_nxt == SW_W'(k)) begin
        nxt_seg = seg_dec(DATA[k*CHR_W +: CHR_W]);
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    hex_d  = hex_q;
    tick_d = 1'b0;
    if (mode_chg) begin
      mode_d = MODE;
      idx_d  = '0;
      hex_d  = {NDIG{SEG_BLANK}};
    end else if (!mode_q) begin
      idx_d      = SEL;
      hex_d      = {NDIG{SEG_BLANK}};
      hex_d[7:0] = sel_seg;
    end else if (presc_tick) begin
      idx_d  = idx_nxt;
      tick_d = 1'b1;
      for (int d = int'(NDIG) - 1; d >= 1; d--) begin
        hex_d[d*8 +: 8] = hex_q[(d-1)*8 +: 8];
      end
      hex_d[7:0] = nxt_seg;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      mode_q <= 1'b0;
      idx_q  <= '0;
      hex_q  <= {NDIG{SEG_BLANK}};
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      hex_q  <= hex_d;
      tick_q <= tick_d;
    end
  end

  assign HEX     = hex_q;
  assign CUR_IDX = idx_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_led7_scroll_mux.sv
// Bench for led7_scroll_mux (NCH=5, NDIG=4, DIV=4): directed scenarios plus
// randomized traffic, checked against a queue-based display model.
module tb_led7_scroll_mux;

  localparam int NCH  = 5;
  localparam int NDIG = 4;
  localparam int DIV  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        pause;
  logic [2:0]  sel;
  logic [14:0] data;
  logic [31:0] hex;
  logic [2:0]  cur_idx;
  logic        tick;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] seg_tab [8] = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hFF, 8'hFF};

  bit         m_mode;
  int         m_presc;
  int         m_idx;
  bit         m_tick;
  logic [7:0] m_dig [$];

  led7_scroll_mux #(
    .NCH  (NCH),
    .NDIG (NDIG),
    .DIV  (DIV)
  ) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .MODE     (mode),
    .PAUSE    (pause),
    .SEL      (sel),
    .DATA     (data),
    .HEX      (hex),
    .CUR_IDX  (cur_idx),
    .TICK     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan_seg(input int k);
    if (k >= NCH) return 8'hFF;
    return seg_tab[int'((data >> (3 * k)) & 15'd7)];
  endfunction

  function automatic logic [31:0] m_hex();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  task automatic blank();
    m_dig = {};
    repeat (NDIG) m_dig.push_back(8'hFF);
  endtask

  // Model of one rising edge, using the inputs currently applied.
  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_presc = 0; m_idx = 0; m_tick = 0;
      blank();
    end else if (mode != m_mode) begin
      m_mode = mode; m_presc = 0; m_idx = 0; m_tick = 0;
      blank();
    end else if (!m_mode) begin
      blank();
      m_dig[0] = chan_seg(int'(sel));
      m_idx    = int'(sel);
      m_tick   = 0;
      m_presc  = 0;
    end else begin
      m_tick = 0;
      if (!pause) begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          m_idx   = (m_idx + 1) % NCH;
          m_dig.push_front(chan_seg(m_idx));
          void'(m_dig.pop_back());
          m_tick  = 1;
        end else begin
          m_presc++;
        end
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("hex", hex, m_hex());
    chk("cur_idx", 32'(cur_idx), 32'(m_idx));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  logic [31:0] scroll_exp [5] = '{32'hFFFFFF86, 32'hFFFF86C7, 32'hFF86C7C7,
                                  32'h86C7C7C0, 32'hC7C7C089};

  initial begin
    blank();
    m_mode = 0; m_presc = 0; m_idx = 0; m_tick = 0;
    rst_n = 1'b0; mode = 1'b0; pause = 1'b0; sel = 3'd0;
    data  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    // Reset
    repeat (2) cyc();
    chk("rst_hex", hex, 32'hFFFF_FFFF);
    chk("rst_idx", 32'(cur_idx), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);

    // Manual select, including an out-of-range channel
    rst_n = 1'b1; sel = 3'd4;
    cyc();
    chk("man_sel4", hex, 32'hFFFF_FFC0);
    sel = 3'd6;
    cyc();
    chk("man_sel6_hex", hex, 32'hFFFF_FFFF);
    chk("man_sel6_idx", 32'(cur_idx), 32'd6);

    // Auto scroll: tick every DIV clocks, wrap back to channel 0
    mode = 1'b1;
    cyc();
    for (int t = 0; t < 5; t++) begin
      repeat (DIV) cyc();
      chk("scroll_tick", 32'(tick), 32'd1);
      chk("scroll_hex", hex, scroll_exp[t]);
    end

    // Pause asserted in the wrap cycle
    repeat (DIV - 1) cyc();
    pause = 1'b1;
    repeat (10) cyc();
    chk("pause_hex", hex, 32'hC7C7_C089);
    chk("pause_tick", 32'(tick), 32'd0);
    pause = 1'b0;
    cyc();
    chk("unpause_tick", 32'(tick), 32'd1);
    chk("unpause_hex", hex, 32'hC7C0_8986);

    // Mode change coinciding with a tick
    repeat (DIV - 1) cyc();
    sel = 3'd2; mode = 1'b0;
    cyc();
    chk("toggle_tick", 32'(tick), 32'd0);
    chk("toggle_hex", hex, 32'hFFFF_FFFF);
    cyc();
    chk("toggle_man", hex, 32'hFFFF_FFC7);
    mode = 1'b1;
    cyc();
    repeat (DIV) cyc();
    chk("restart_tick", 32'(tick), 32'd1);
    chk("restart_hex", hex, 32'hFFFF_FF86);

    // Reset mid-scroll
    repeat (3 * DIV) cyc();
    chk("pre_rst_hex", hex, 32'h86C7_C7C0);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_hex", hex, 32'hFFFF_FFFF);
    chk("mid_rst_idx", 32'(cur_idx), 32'd0);
    rst_n = 1'b1; mode = 1'b0; sel = 3'd4;
    cyc();
    chk("post_rst_manual", hex, 32'hFFFF_FFC0);

    // Randomized traffic
    mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(99) != 0);
      if ($urandom_range(59) == 0) mode = ~mode;
      pause = ($urandom_range(3) == 0);
      sel   = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) data = 15'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
